// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the ALU command sequencer: the ALU
//                opcode map, the issue FSM state encoding and the packed
//                command record stored in the command FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // ALU opcode map
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    // Queued command: opcode, operand A, operand B, accumulator select
    localparam int CMD_W = 20;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } cmd_t;

    // The ALU only produces defined results for ADD with carry_in=0 and
    // SUB with carry_in=1, so carry_in is derived from the opcode.
    function automatic logic carry_in_for(input logic [2:0] op);
        return (op == OP_SUB);
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with full/empty flags.
//                Head entry is presented combinationally on 'head'.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                push/push_data - write request (ignored when full)
//                pop            - read request (ignored when empty)
//                head           - oldest entry
//                full/empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int              c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Issue stage for the 8-bit combinational ALU. Commands are
//                queued over a valid/ready port, issued one at a time onto
//                the ALU inputs, held for SETTLE cycles, then the ALU outputs
//                are captured and returned on a valid/ready result port.
//                An 8-bit accumulator tracks the last captured result and
//                can replace operand A of a command.
//  Ports       : clk, rst_n                      - clock, async active-low reset
//                cmd_valid/cmd_ready/cmd_*       - command input port
//                alu_a/alu_b/alu_opcode/
//                alu_carry_in                    - drive to the ALU
//                alu_out/alu_c_flag/alu_carry_out- sampled from the ALU
//                res_valid/res_ready/res_*       - result output port
//                acc                             - accumulator
//                busy                            - work queued or in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    // command port
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    // ALU interface
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_c_flag,
    input  logic       alu_carry_out,
    // result port
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_c_flag,
    output logic       res_carry,
    output logic [2:0] res_op,
    // status
    output logic [7:0] acc,
    output logic       busy
);

    localparam int                 c_cnt_w      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_ld  = c_cnt_w'(SETTLE - 1);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t              w_push_cmd;
    logic [CMD_W-1:0]  w_fifo_head;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    assign w_head     = cmd_t'(w_fifo_head);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    seq_state_t         r_state;
    logic [c_cnt_w-1:0] r_settle_cnt;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [2:0]         r_alu_op;
    logic               r_alu_cin;
    logic               r_res_valid;
    logic [7:0]         r_res_data;
    logic               r_res_c_flag;
    logic               r_res_carry;
    logic [2:0]         r_res_op;
    logic [7:0]         r_acc;

    // A new command is taken from idle, or straight out of HOLD on the
    // cycle the current result is consumed (back-to-back issue).
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && res_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_cin    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_c_flag <= 1'b0;
            r_res_carry  <= 1'b0;
            r_res_op     <= '0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_settle_cnt <= c_settle_ld;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_settle_cnt == '0) begin
                        r_res_data   <= alu_out;
                        r_res_c_flag <= alu_c_flag;
                        r_res_carry  <= alu_carry_out;
                        r_res_op     <= r_alu_op;
                        r_acc        <= alu_out;
                        r_res_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_pop ? ST_DRIVE : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Operand A is resolved at pop time so it sees the accumulator
            // value left by every previously captured result. The ALU
            // inputs are only updated on issue and otherwise hold steady.
            if (w_pop) begin
                r_alu_a   <= w_head.use_acc ? r_acc : w_head.a;
                r_alu_b   <= w_head.b;
                r_alu_op  <= w_head.op;
                r_alu_cin <= carry_in_for(w_head.op);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready    = !w_full;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_op;
    assign alu_carry_in = r_alu_cin;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_c_flag   = r_res_c_flag;
    assign res_carry    = r_res_carry;
    assign res_op       = r_res_op;
    assign acc          = r_acc;
    assign busy         = (r_state != ST_IDLE) || !w_empty;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//                8-bit ALU attached. Stimulus pushes expected results into a
//                scoreboard queue; a monitor pops and compares on each
//                accepted result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic       alu_carry_in;
    logic [7:0] alu_out;
    logic       alu_c_flag;
    logic       alu_carry_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_c_flag;
    logic       res_carry;
    logic [2:0] res_op;
    logic [7:0] acc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic       cf;
        logic       co;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ed;
        logic       ecf;
        logic       eco;
    } vec_t;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH  (4),
        .SETTLE (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_use_acc   (cmd_use_acc),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_carry_in  (alu_carry_in),
        .alu_out       (alu_out),
        .alu_c_flag    (alu_c_flag),
        .alu_carry_out (alu_carry_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_c_flag    (res_c_flag),
        .res_carry     (res_carry),
        .res_op        (res_op),
        .acc           (acc),
        .busy          (busy)
    );

    // Behavioural ALU
    logic [8:0] w_sum;
    always_comb begin
        w_sum         = '0;
        alu_out       = '0;
        alu_carry_out = 1'b0;
        alu_c_flag    = (alu_a > alu_b);
        case (alu_opcode)
            OP_ADD, OP_SUB: begin
                w_sum = {1'b0, alu_a} + {1'b0, ((alu_opcode == OP_SUB) ? ~alu_b : alu_b)}
                        + {8'd0, alu_carry_in};
                alu_out       = w_sum[7:0];
                alu_carry_out = w_sum[8];
            end
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_CMP:  alu_out = {7'd0, alu_a > alu_b};
            OP_SHLA: {alu_carry_out, alu_out} = {alu_a, 1'b0};
            OP_SHLB: {alu_carry_out, alu_out} = {alu_b, 1'b0};
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a result is consumed on the next rising edge
    // whenever valid and ready are both high at the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected actual op=%b data=%h required none", res_op, res_data);
            end else begin
                e = sb.pop_front();
                if ({res_op, res_data, res_c_flag, res_carry} !== {e.op, e.data, e.cf, e.co}) begin
                    errors++;
                    $display("FAIL result actual op=%b data=%h cf=%b co=%b required op=%b data=%h cf=%b co=%b",
                             res_op, res_data, res_c_flag, res_carry, e.op, e.data, e.cf, e.co);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic [7:0] ed, input logic ecf, input logic eco);
        logic rdy;
        bit   ok;
        ok          = 0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (ok) sb.push_back('{op: op, data: ed, cf: ecf, co: eco});
        else    check("push_timeout", 32'd0, 32'd1);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_op(input logic [2:0] op);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (alu_opcode == op) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("op_issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        vec_t fv [6];
        int   k;
        int   hits;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        res_ready   = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_acc",       {24'd0, acc},       32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_alu_a",     {24'd0, alu_a},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- add + latency ----------------
        push(OP_ADD, 8'h05, 8'h03, 1'b0, 8'h08, 1'b1, 1'b0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                k = i;
                break;
            end
        end
        check("add_latency_edges", k, 32'd4);
        check("add_carry_in", {31'd0, alu_carry_in}, 32'd0);
        wait_idle();

        // ---------------- subtract drives carry_in ----------------
        @(posedge clk);
        #1;
        push(OP_SUB, 8'h10, 8'h03, 1'b0, 8'h0D, 1'b1, 1'b1);
        wait_op(OP_SUB);
        check("sub_carry_in", {31'd0, alu_carry_in}, 32'd1);
        wait_idle();

        // ---------------- accumulator chain ----------------
        @(posedge clk);
        #1;
        push(OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b1, 1'b0);
        push(OP_AND, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
        wait_op(OP_AND);
        check("chain_alu_a", {24'd0, alu_a}, 32'h0000_00FF);
        wait_idle();
        check("chain_acc", {24'd0, acc}, 32'h0000_003C);

        // ---------------- compare / shift ----------------
        @(posedge clk);
        #1;
        push(OP_CMP,  8'h80, 8'h7F, 1'b0, 8'h01, 1'b1, 1'b0);
        push(OP_SHLA, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b1);
        wait_idle();

        // ---------------- full FIFO + backpressure ----------------
        fv[0] = '{op: OP_XOR,  a: 8'hAA, b: 8'h55, ed: 8'hFF, ecf: 1'b1, eco: 1'b0};
        fv[1] = '{op: OP_ADD,  a: 8'hFF, b: 8'h01, ed: 8'h00, ecf: 1'b1, eco: 1'b1};
        fv[2] = '{op: OP_SHLB, a: 8'h01, b: 8'hC0, ed: 8'h80, ecf: 1'b0, eco: 1'b1};
        fv[3] = '{op: OP_SUB,  a: 8'h03, b: 8'h05, ed: 8'hFE, ecf: 1'b0, eco: 1'b0};
        fv[4] = '{op: OP_ADD,  a: 8'h7F, b: 8'h01, ed: 8'h80, ecf: 1'b1, eco: 1'b0};
        fv[5] = '{op: OP_AND,  a: 8'h11, b: 8'h22, ed: 8'h00, ecf: 1'b0, eco: 1'b0};
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic rdy;
            cmd_valid   = 1'b1;
            cmd_op      = fv[i].op;
            cmd_a       = fv[i].a;
            cmd_b       = fv[i].b;
            cmd_use_acc = 1'b0;
            @(negedge clk);
            rdy = cmd_ready;
            check($sformatf("full_ready_%0d", i), {31'd0, rdy}, (i < 5) ? 32'd1 : 32'd0);
            @(posedge clk);
            if (rdy) sb.push_back('{op: fv[i].op, data: fv[i].ed, cf: fv[i].ecf, co: fv[i].eco});
            #1;
        end
        cmd_valid = 1'b0;
        check("full_busy", {31'd0, busy}, 32'd1);

        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                k = 1;
                break;
            end
        end
        check("bp_res_valid", k, 32'd1);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 8'hFF || res_op !== OP_XOR ||
                res_c_flag !== 1'b1 || res_carry !== 1'b0 || alu_opcode !== OP_XOR ||
                alu_a !== 8'hAA)
                hits++;
        end
        check("bp_stable_cycles_bad", hits, 32'd0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_drive", {21'd0, alu_opcode, alu_a}, {21'd0, OP_ADD, 8'hFF});
        check("bp_valid_dropped", {31'd0, res_valid}, 32'd0);
        wait_idle();
        check("full_acc", {24'd0, acc}, 32'h0000_0080);

        // ---------------- reset mid-operation ----------------
        @(posedge clk);
        #1;
        push(OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        push(OP_OR,  8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        push(OP_XOR, 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_acc",       {24'd0, acc},       32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) hits++;
        end
        check("post_rst_quiet_bad", hits, 32'd0);

        // ---------------- recovery ----------------
        @(posedge clk);
        #1;
        push(OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        wait_idle();
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
